conv_event_dispatcher: RTL and testbench
========================================

# conv_event_dispatcher

Downstream consumer of the convolution event FIFO. Pops one spike event `{y, x}` at a time, accounting for the FIFO's one-cycle registered read. Expands each event into the in-bounds set of `(output x, output y, kernel index)` tuples of a K×K "same"-padded convolution. Tuples stream to the convolution accumulator over a valid/ready handshake.

## Interface

Parameters:
- `COORD_BITS`, 8: width of each event coordinate. FIFO word is `{y, x}`, `2*COORD_BITS` bits, x in the low half.
- `IMG_WIDTH`, 32: output/input map width; legal x is 0..IMG_WIDTH-1.
- `IMG_HEIGHT`, 32: map height; legal y is 0..IMG_HEIGHT-1.
- `KERNEL_SIZE`, 3: K. Must be odd, ≥1. R = (K-1)/2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_read_en`  out  1  pop request to FIFO.
- `fifo_read_data`  in  2*COORD_BITS  FIFO registered read data, valid the cycle after a pop.
- `fifo_empty`  in  1  FIFO empty flag.
- `out_valid`  out  1  tuple valid.
- `out_ready`  in  1  consumer accepts tuple.
- `out_x`  out  COORD_BITS  output neuron x.
- `out_y`  out  COORD_BITS  output neuron y.
- `out_kidx`  out  clog2(K*K)  kernel weight index, ky*K+kx.
- `out_last`  out  1  final tuple of current event.
- `drop_pulse`  out  1  one-cycle pulse: event discarded (coordinate out of range).
- `busy`  out  1  state ≠ IDLE.

## Operation

- States: IDLE, WAIT, EMIT.
- **IDLE**
  - `fifo_read_en` = !`fifo_empty` (combinational).
  - On a pop → WAIT.
- **WAIT**
  - `fifo_read_data` is valid; capture x and y.
  - If x ≥ IMG_WIDTH or y ≥ IMG_HEIGHT: → IDLE and assert `drop_pulse` (registered) for exactly one cycle.
  - Otherwise compute the kx and ky bounds in COORD_BITS+1-bit unsigned arithmetic:
    - kx_lo = max(0, x+R-(IMG_WIDTH-1))
    - kx_hi = min(K-1, x+R)
    - ky_lo and ky_hi are the same expressions in y and IMG_HEIGHT.
  - Load (ky, kx) = (ky_lo, kx_lo), then → EMIT.
- **EMIT**
  - `out_valid` = 1. Outputs are:
    - `out_x` = x+R-kx
    - `out_y` = y+R-ky
    - `out_kidx` = ky*K+kx
    - `out_last` = (ky==ky_hi && kx==kx_hi)
  - Order is ky outer, kx inner, one tuple per accepted handshake. There are no bubbles and no out-of-bounds tuples.
  - On handshake with !`out_last`:
    - If kx==kx_hi, set kx=kx_lo and increment ky.
    - Otherwise increment kx.
  - On handshake with `out_last`:
    - If !`fifo_empty`, assert `fifo_read_en` in the same cycle and → WAIT.
    - Otherwise → IDLE.
- The centre tap (kx=ky=R) is always in bounds for a legal event, so every legal event emits ≥1 tuple.
- `fifo_read_en` is never asserted when `fifo_empty`=1 and never asserted in WAIT.

## Timing

- Reset values: state IDLE, `out_valid` 0, `out_last` 0, `fifo_read_en` 0, `drop_pulse` 0, `busy` 0, `out_x`/`out_y`/`out_kidx` 0.
- During `rst`=1, `fifo_read_en` is forced 0.
- Latency: pop at cycle T → data captured in WAIT at T+1 → first `out_valid` at T+2.
- Back-to-back events: last handshake at cycle T → next event's first tuple at T+2. That is one bubble cycle (the WAIT cycle).
- Backpressure: while `out_valid` && !`out_ready`, all `out_*` hold stable. `out_valid` never deasserts until the handshake completes.
- `drop_pulse` fires at T+2 for a pop at T; next pop is possible at T+2.
- Reset mid-WAIT or mid-EMIT:
  - The next cycle is IDLE with `out_valid`=0.
  - The in-flight event is lost; the FIFO pointer has already advanced. This is accepted behaviour.
- `out_ready` is ignored outside EMIT.

## Test plan

All scenarios use defaults: 32×32 map, K=3, R=1.

- **Interior event:** event (x=5,y=7), `out_ready`=1.
  - First `out_valid` 2 cycles after `fifo_read_en`.
  - 9 consecutive tuples, first (6,8,kidx 0), last (4,6,kidx 8) with `out_last`=1.
- **Corner (0,0):** exactly 4 tuples (1,1,0), (0,1,1), (1,0,3), (0,0,4). `out_last` on the 4th only.
- **Corner (31,31):** exactly 4 tuples (31,31,4), (30,31,5), (31,30,7), (30,30,8). `out_last` on the 4th only.
- **Backpressure and back-to-back:**
  - Two events (5,7) then (10,10) queued; `out_ready` pseudo-random 50%.
  - 18 tuples total, in order, none duplicated or lost, outputs stable while stalled.
  - Exactly one bubble between `out_last` of event 1 and first tuple of event 2 when `out_ready`=1.
- **Illegal coordinate:** event (40,3) followed by (2,2).
  - No `out_valid` for the first event; `drop_pulse` high for exactly 1 cycle.
  - The second event emits 9 tuples normally.
- **Reset mid-EMIT:** `rst`=1 for one cycle during the 4th tuple of event (5,7).
  - Next cycle `out_valid`=0, `busy`=0, `fifo_read_en`=0.
  - A following event (3,3) emits all 9 tuples correctly.

Source files
------------

// File: rtl/conv_event_dispatcher.sv
// Pops spike events from the convolution event FIFO and expands each one into the
// in-bounds (out_x, out_y, kernel index) tuples of a KxK "same"-padded convolution.
module conv_event_dispatcher #(
  parameter int COORD_BITS  = 8,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3,
  localparam int KIDX_BITS  = (KERNEL_SIZE * KERNEL_SIZE > 1) ?
                              $clog2(KERNEL_SIZE * KERNEL_SIZE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    fifo_read_en,
  input  logic [2*COORD_BITS-1:0] fifo_read_data,
  input  logic                    fifo_empty,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COORD_BITS-1:0]   out_x,
  output logic [COORD_BITS-1:0]   out_y,
  output logic [KIDX_BITS-1:0]    out_kidx,
  output logic                    out_last,
  output logic                    drop_pulse,
  output logic                    busy
);

  localparam int R  = (KERNEL_SIZE - 1) / 2;
  localparam int AW = COORD_BITS + 1;

  localparam logic [AW-1:0] R_A     = AW'(R);
  localparam logic [AW-1:0] K_A     = AW'(KERNEL_SIZE);
  localparam logic [AW-1:0] K_MAX_A = AW'(KERNEL_SIZE - 1);
  localparam logic [AW-1:0] W_A     = AW'(IMG_WIDTH);
  localparam logic [AW-1:0] H_A     = AW'(IMG_HEIGHT);
  localparam logic [AW-1:0] W_MAX_A = AW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0] H_MAX_A = AW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [COORD_BITS-1:0]  x_q, x_d, y_q, y_d;
  logic [AW-1:0]          kx_q, kx_d, ky_q, ky_d;
  logic [AW-1:0]          kx_lo_q, kx_lo_d, kx_hi_q, kx_hi_d;
  logic [AW-1:0]          ky_lo_q, ky_lo_d, ky_hi_q, ky_hi_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   drop_q, drop_d, busy_q, busy_d;
  logic [COORD_BITS-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
  logic [KIDX_BITS-1:0]   out_kidx_q, out_kidx_d;

  logic [AW-1:0]          rd_x, rd_y;
  logic [AW-1:0]          kx_lo_c, kx_hi_c, ky_lo_c, ky_hi_c;
  logic                   x_oob, y_oob;
  logic                   handshake;
  logic                   pop;
  logic                   emit_d;

  // Kernel bounds of the event on the FIFO read port; only meaningful in WAIT.
  assign rd_x    = {1'b0, fifo_read_data[COORD_BITS-1:0]};
  assign rd_y    = {1'b0, fifo_read_data[2*COORD_BITS-1:COORD_BITS]};
  assign x_oob   = (rd_x >= W_A);
  assign y_oob   = (rd_y >= H_A);
  assign kx_lo_c = ((rd_x + R_A) > W_MAX_A) ? (rd_x + R_A - W_MAX_A) : {AW{1'b0}};
  assign kx_hi_c = ((rd_x + R_A) < K_MAX_A) ? (rd_x + R_A) : K_MAX_A;
  assign ky_lo_c = ((rd_y + R_A) > H_MAX_A) ? (rd_y + R_A - H_MAX_A) : {AW{1'b0}};
  assign ky_hi_c = ((rd_y + R_A) < K_MAX_A) ? (rd_y + R_A) : K_MAX_A;

  // out_valid_q is only ever set in EMIT, so it doubles as the state qualifier.
  assign handshake = out_valid_q & out_ready;

  // Next-state, kernel walk and registered-output precomputation.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    kx_lo_d  = kx_lo_q;
    kx_hi_d  = kx_hi_q;
    ky_lo_d  = ky_lo_q;
    ky_hi_d  = ky_hi_q;
    drop_d   = 1'b0;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        x_d = rd_x[COORD_BITS-1:0];
        y_d = rd_y[COORD_BITS-1:0];
        if (x_oob || y_oob) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          kx_lo_d = kx_lo_c;
          kx_hi_d = kx_hi_c;
          ky_lo_d = ky_lo_c;
          ky_hi_d = ky_hi_c;
          kx_d    = kx_lo_c;
          ky_d    = ky_lo_c;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (handshake) begin
          if (out_last_q) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end else if (kx_q == kx_hi_q) begin
            kx_d = kx_lo_q;
            ky_d = ky_q + {{(AW-1){1'b0}}, 1'b1};
          end else begin
            kx_d = kx_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    fifo_read_en = pop & ~rst;

    // Outputs are registered from the post-transition walk position.
    emit_d      = (state_d == S_EMIT);
    out_valid_d = emit_d;
    busy_d      = (state_d != S_IDLE);
    if (emit_d) begin
      out_x_d    = COORD_BITS'({1'b0, x_d} + R_A - kx_d);
      out_y_d    = COORD_BITS'({1'b0, y_d} + R_A - ky_d);
      out_kidx_d = KIDX_BITS'(ky_d * K_A + kx_d);
      out_last_d = (ky_d == ky_hi_d) && (kx_d == kx_hi_d);
    end else begin
      out_x_d    = {COORD_BITS{1'b0}};
      out_y_d    = {COORD_BITS{1'b0}};
      out_kidx_d = {KIDX_BITS{1'b0}};
      out_last_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= {COORD_BITS{1'b0}};
      y_q         <= {COORD_BITS{1'b0}};
      kx_q        <= {AW{1'b0}};
      ky_q        <= {AW{1'b0}};
      kx_lo_q     <= {AW{1'b0}};
      kx_hi_q     <= {AW{1'b0}};
      ky_lo_q     <= {AW{1'b0}};
      ky_hi_q     <= {AW{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_x_q     <= {COORD_BITS{1'b0}};
      out_y_q     <= {COORD_BITS{1'b0}};
      out_kidx_q  <= {KIDX_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      kx_lo_q     <= kx_lo_d;
      kx_hi_q     <= kx_hi_d;
      ky_lo_q     <= ky_lo_d;
      ky_hi_q     <= ky_hi_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_kidx_q  <= out_kidx_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_kidx   = out_kidx_q;
  assign drop_pulse = drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_conv_event_dispatcher.sv
// Self-checking bench for conv_event_dispatcher: a registered-read FIFO model feeds
// events, a scoreboard of expected tuples is filled on push and drained on handshake.
module tb_conv_event_dispatcher;

  localparam int CB = 8;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int K  = 3;
  localparam int R  = 1;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_read_en;
  logic [2*CB-1:0] fifo_read_data;
  logic          fifo_empty;
  logic          out_valid;
  logic          out_ready;
  logic [CB-1:0] out_x;
  logic [CB-1:0] out_y;
  logic [KW-1:0] out_kidx;
  logic          out_last;
  logic          drop_pulse;
  logic          busy;

  conv_event_dispatcher #(
    .COORD_BITS (CB),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .KERNEL_SIZE(K)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_read_en  (fifo_read_en),
    .fifo_read_data(fifo_read_data),
    .fifo_empty    (fifo_empty),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_kidx      (out_kidx),
    .out_last      (out_last),
    .drop_pulse    (drop_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int k; int last; int first; int cyc;
  } tup_t;

  typedef struct {
    int x; int y; int n;
    int f_x; int f_y; int f_k;
    int l_x; int l_y; int l_k;
    int drop;
  } vec_t;

  tup_t exp_q[$];
  tup_t log_q[$];
  vec_t vecs[5];

  int n_checks = 0;
  int n_pass   = 0;

  // FIFO model with a registered read port.
  logic [2*CB-1:0] fifo_mem [0:255];
  int              wptr = 0;
  int              rptr = 0;
  logic            push_en;
  logic [2*CB-1:0] push_data;

  always @(posedge clk) begin
    if (push_en) begin
      fifo_mem[wptr[7:0]] <= push_data;
      wptr <= wptr + 1;
    end
    if (fifo_read_en && (rptr != wptr)) begin
      fifo_read_data <= fifo_mem[rptr[7:0]];
      rptr <= rptr + 1;
    end
  end

  assign fifo_empty = (rptr == wptr);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enqueue an event in the FIFO and its expected tuples in the scoreboard.
  task automatic push_event(input int x, input int y);
    int   n;
    int   idx;
    tup_t t;
    n = 0;
    if (x < W && y < H) begin
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          if (x + R - kx >= 0 && x + R - kx < W && y + R - ky >= 0 && y + R - ky < H) n++;
      idx = 0;
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          if (x + R - kx >= 0 && x + R - kx < W && y + R - ky >= 0 && y + R - ky < H) begin
            t.x = x + R - kx;
            t.y = y + R - ky;
            t.k = ky * K + kx;
            t.first = (idx == 0) ? 1 : 0;
            t.last  = (idx == n - 1) ? 1 : 0;
            t.cyc   = 0;
            exp_q.push_back(t);
            idx++;
          end
    end
    push_data = {y[CB-1:0], x[CB-1:0]};
    push_en   = 1'b1;
    tick();
    push_en   = 1'b0;
  endtask

  task automatic run_idle(input int budget, input bit rnd);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy || !fifo_empty) && c < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      c++;
    end
    check("drain_within_budget", int'(c < budget), 1);
    out_ready = 1'b1;
    repeat (2) tick();
  endtask

  // Monitor: scoreboard, latency, stall stability and drop-pulse width.
  int   ncyc = 0;
  int   last_pop = -100;
  int   hs_count = 0;
  int   drop_cnt = 0;
  bit   lat_done = 1'b0;
  bit   prev_stall = 1'b0;
  bit   prev_drop = 1'b0;
  int   prev_x, prev_y, prev_k, prev_l;
  tup_t mon_e, mon_t;

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        prev_stall = 1'b0;
        lat_done   = 1'b0;
      end else begin
        if (fifo_read_en) begin
          check("rd_en_with_data", int'(fifo_empty), 0);
          last_pop = ncyc;
        end
        if (drop_pulse) begin
          drop_cnt++;
          check("drop_single_cycle", int'(prev_drop), 0);
        end
        if (prev_stall) begin
          check("stall_valid_held", int'(out_valid), 1);
          check("stall_x_held", int'(out_x), prev_x);
          check("stall_y_held", int'(out_y), prev_y);
          check("stall_kidx_held", int'(out_kidx), prev_k);
          check("stall_last_held", int'(out_last), prev_l);
        end
        if (out_valid && exp_q.size() != 0 && !lat_done) begin
          if (exp_q[0].first == 1) begin
            check("pop_to_first_valid", ncyc - last_pop, 2);
            lat_done = 1'b1;
          end
        end
        if (out_valid && out_ready) begin
          check("tuple_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("tuple_x", int'(out_x), mon_e.x);
            check("tuple_y", int'(out_y), mon_e.y);
            check("tuple_kidx", int'(out_kidx), mon_e.k);
            check("tuple_last", int'(out_last), mon_e.last);
          end
          mon_t.x = int'(out_x);
          mon_t.y = int'(out_y);
          mon_t.k = int'(out_kidx);
          mon_t.last = int'(out_last);
          mon_t.first = 0;
          mon_t.cyc = ncyc;
          log_q.push_back(mon_t);
          hs_count++;
          lat_done = 1'b0;
        end
        prev_stall = out_valid && !out_ready;
        prev_x = int'(out_x);
        prev_y = int'(out_y);
        prev_k = int'(out_kidx);
        prev_l = int'(out_last);
      end
      prev_drop = drop_pulse;
    end
  end

  int d0;
  int base;
  int c;
  int nlast;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    push_en   = 1'b0;
    push_data = '0;

    //             x   y  n  first      last      drop
    vecs[0] = '{5,  7,  9, 6, 8, 0,  4, 6, 8,  0};
    vecs[1] = '{0,  0,  4, 1, 1, 0,  0, 0, 4,  0};
    vecs[2] = '{31, 31, 4, 31, 31, 4, 30, 30, 8, 0};
    vecs[3] = '{40, 3,  0, 0, 0, 0,  0, 0, 0,  1};
    vecs[4] = '{2,  2,  9, 3, 3, 0,  1, 1, 8,  0};

    repeat (3) tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(fifo_read_en), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_drop", int'(drop_pulse), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_kidx", int'(out_kidx), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Single events, out_ready held high.
    for (int i = 0; i < 5; i++) begin
      log_q.delete();
      d0 = drop_cnt;
      push_event(vecs[i].x, vecs[i].y);
      run_idle(200, 1'b0);
      check("vec_tuple_count", log_q.size(), vecs[i].n);
      check("vec_drop_count", drop_cnt - d0, vecs[i].drop);
      if (vecs[i].n > 0 && log_q.size() == vecs[i].n) begin
        check("vec_first_x", log_q[0].x, vecs[i].f_x);
        check("vec_first_y", log_q[0].y, vecs[i].f_y);
        check("vec_first_k", log_q[0].k, vecs[i].f_k);
        check("vec_last_x", log_q[vecs[i].n-1].x, vecs[i].l_x);
        check("vec_last_y", log_q[vecs[i].n-1].y, vecs[i].l_y);
        check("vec_last_k", log_q[vecs[i].n-1].k, vecs[i].l_k);
        check("vec_last_flag", log_q[vecs[i].n-1].last, 1);
        check("vec_burst_len", log_q[vecs[i].n-1].cyc - log_q[0].cyc, vecs[i].n - 1);
      end
      nlast = 0;
      foreach (log_q[j]) nlast += log_q[j].last;
      check("vec_last_flags", nlast, (vecs[i].n > 0) ? 1 : 0);
    end

    // Back-to-back corners with out_ready high: one bubble between events.
    log_q.delete();
    push_event(0, 0);
    push_event(31, 31);
    run_idle(200, 1'b0);
    check("b2b_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      check("b2b_no_bubble_in_event", log_q[1].cyc - log_q[0].cyc, 1);
      check("b2b_one_bubble", log_q[4].cyc - log_q[3].cyc, 2);
      check("b2b_second_first_k", log_q[4].k, 4);
      check("b2b_second_last", log_q[7].last, 1);
    end

    // Random backpressure across two queued events.
    log_q.delete();
    push_event(5, 7);
    push_event(10, 10);
    run_idle(400, 1'b1);
    check("bp_count", log_q.size(), 18);
    if (log_q.size() == 18) begin
      check("bp_event1_last", log_q[8].last, 1);
      check("bp_event2_first_x", log_q[9].x, 11);
      check("bp_event2_last", log_q[17].last, 1);
    end

    // Reset while the 4th tuple of (5,7) is on the output.
    out_ready = 1'b1;
    log_q.delete();
    base = hs_count;
    push_event(5, 7);
    c = 0;
    while (hs_count - base < 3 && c < 50) begin
      tick();
      c++;
    end
    check("rstmid_reached_4th", hs_count - base, 3);
    check("rstmid_4th_valid", int'(out_valid), 1);
    check("rstmid_4th_kidx", int'(out_kidx), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_rd_en", int'(fifo_read_en), 0);
    exp_q.delete();
    log_q.delete();
    tick();
    push_event(3, 3);
    run_idle(200, 1'b0);
    check("rstmid_next_count", log_q.size(), 9);
    if (log_q.size() == 9) begin
      check("rstmid_next_first_x", log_q[0].x, 4);
      check("rstmid_next_first_k", log_q[0].k, 0);
      check("rstmid_next_last_x", log_q[8].x, 2);
      check("rstmid_next_last_k", log_q[8].k, 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
